// File: rtl/conv_sequencer.sv
// Control sequencer for the 4x4-filter convolution datapath: filter/band load,
// per-window MAC passes, grouped result writes and band sliding, start to done.
module conv_sequencer #(
  parameter int unsigned OUT_ROWS = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cout_filter_write_index,
  input  logic       cout_mac_index,
  input  logic       cout_buff_write_index,
  input  logic       cout_buff_read_index,
  output logic       load_x,
  output logic       sel_x,
  output logic       load_y,
  output logic       sel_y,
  output logic       load_z,
  output logic       sel_z,
  output logic [1:0] mem_addr_sel,
  output logic       mem_write_en,
  output logic       write_buff_en,
  output logic       write_buff_counter_en,
  output logic       shift_buff,
  output logic       read_buff_counter_en,
  output logic       write_filter_buff_en,
  output logic       write_filter_buff_counter_en,
  output logic       read_filter_buff_counter_en,
  output logic       write_window_buff_en,
  output logic       clear_mac,
  output logic       partial_res_en,
  output logic       shift_reg_en,
  output logic       finalize_shift_reg,
  output logic       done,
  output logic       busy
);

  localparam int unsigned GROUP = 4;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_LD_FILT, S_LD_BUFF, S_LD_WIN, S_MAC,
    S_ACC, S_WR, S_SHIFT, S_REFILL, S_DONE
  } state_t;

  typedef struct packed {
    logic       load_x;
    logic       sel_x;
    logic       load_y;
    logic       sel_y;
    logic       load_z;
    logic       sel_z;
    logic [1:0] mem_addr_sel;
    logic       mem_write_en;
    logic       write_buff_en;
    logic       write_buff_counter_en;
    logic       shift_buff;
    logic       read_buff_counter_en;
    logic       write_filter_buff_en;
    logic       write_filter_buff_counter_en;
    logic       read_filter_buff_counter_en;
    logic       write_window_buff_en;
    logic       clear_mac;
    logic       partial_res_en;
    logic       shift_reg_en;
    logic       finalize_shift_reg;
    logic       done;
    logic       busy;
  } ctrl_t;

  state_t     state_q, state_d;
  logic [3:0] row_cnt_q, row_cnt_d;
  logic [1:0] grp_cnt_q, grp_cnt_d;
  logic       row_end_q, row_end_d;
  ctrl_t      ctrl_q, ctrl_d;

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    grp_cnt_d = grp_cnt_q;
    row_end_d = row_end_q;
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_INIT;
      S_INIT:    state_d = S_LD_FILT;
      S_LD_FILT: if (cout_filter_write_index) state_d = S_LD_BUFF;
      S_LD_BUFF: if (cout_buff_write_index) state_d = S_LD_WIN;
      S_LD_WIN:  state_d = S_MAC;
      S_MAC:     if (cout_mac_index) state_d = S_ACC;
      S_ACC: begin
        grp_cnt_d = grp_cnt_q + 2'd1;
        if (cout_buff_read_index) begin
          row_end_d = 1'b1;
          state_d   = S_WR;
        end else if (grp_cnt_q == 2'(GROUP - 1)) begin
          state_d = S_WR;
        end else begin
          state_d = S_LD_WIN;
        end
      end
      S_WR: begin
        grp_cnt_d = '0;
        if (!row_end_q)                          state_d = S_LD_WIN;
        else if (row_cnt_q == 4'(OUT_ROWS - 1))  state_d = S_DONE;
        else                                     state_d = S_SHIFT;
      end
      S_SHIFT:   state_d = S_REFILL;
      S_REFILL: begin
        row_cnt_d = row_cnt_q + 4'd1;
        row_end_d = 1'b0;
        state_d   = S_LD_WIN;
      end
      S_DONE: begin
        row_cnt_d = '0;
        grp_cnt_d = '0;
        row_end_d = 1'b0;
        state_d   = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so the output
  // flops always reflect the current state without a decode stage after it.
  always_comb begin
    ctrl_d      = '0;
    ctrl_d.busy = (state_d != S_IDLE);
    unique case (state_d)
      S_INIT: begin
        ctrl_d.load_x = 1'b1;
        ctrl_d.load_y = 1'b1;
        ctrl_d.load_z = 1'b1;
      end
      S_LD_FILT: begin
        ctrl_d.mem_addr_sel                 = 2'd1;
        ctrl_d.write_filter_buff_en         = 1'b1;
        ctrl_d.write_filter_buff_counter_en = 1'b1;
        ctrl_d.load_y                       = 1'b1;
        ctrl_d.sel_y                        = 1'b1;
      end
      S_LD_BUFF: begin
        ctrl_d.write_buff_en         = 1'b1;
        ctrl_d.write_buff_counter_en = 1'b1;
        ctrl_d.load_x                = 1'b1;
        ctrl_d.sel_x                 = 1'b1;
      end
      S_LD_WIN: begin
        ctrl_d.write_window_buff_en = 1'b1;
        ctrl_d.clear_mac            = 1'b1;
      end
      S_MAC: begin
        ctrl_d.read_filter_buff_counter_en = 1'b1;
        ctrl_d.partial_res_en              = 1'b1;
      end
      S_ACC: begin
        ctrl_d.shift_reg_en         = 1'b1;
        ctrl_d.read_buff_counter_en = 1'b1;
      end
      S_WR: begin
        ctrl_d.finalize_shift_reg = 1'b1;
        ctrl_d.mem_addr_sel       = 2'd2;
        ctrl_d.mem_write_en       = 1'b1;
        ctrl_d.load_z             = 1'b1;
        ctrl_d.sel_z              = 1'b1;
      end
      S_SHIFT:  ctrl_d.shift_buff = 1'b1;
      S_REFILL: begin
        ctrl_d.write_buff_en = 1'b1;
        ctrl_d.load_x        = 1'b1;
        ctrl_d.sel_x         = 1'b1;
      end
      S_DONE:   ctrl_d.done = 1'b1;
      default:  ctrl_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      row_cnt_q <= '0;
      grp_cnt_q <= '0;
      row_end_q <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      grp_cnt_q <= grp_cnt_d;
      row_end_q <= row_end_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign load_x                       = ctrl_q.load_x;
  assign sel_x                        = ctrl_q.sel_x;
  assign load_y                       = ctrl_q.load_y;
  assign sel_y                        = ctrl_q.sel_y;
  assign load_z                       = ctrl_q.load_z;
  assign sel_z                        = ctrl_q.sel_z;
  assign mem_addr_sel                 = ctrl_q.mem_addr_sel;
  assign mem_write_en                 = ctrl_q.mem_write_en;
  assign write_buff_en                = ctrl_q.write_buff_en;
  assign write_buff_counter_en        = ctrl_q.write_buff_counter_en;
  assign shift_buff                   = ctrl_q.shift_buff;
  assign read_buff_counter_en         = ctrl_q.read_buff_counter_en;
  assign write_filter_buff_en         = ctrl_q.write_filter_buff_en;
  assign write_filter_buff_counter_en = ctrl_q.write_filter_buff_counter_en;
  assign read_filter_buff_counter_en  = ctrl_q.read_filter_buff_counter_en;
  assign write_window_buff_en         = ctrl_q.write_window_buff_en;
  assign clear_mac                    = ctrl_q.clear_mac;
  assign partial_res_en               = ctrl_q.partial_res_en;
  assign shift_reg_en                 = ctrl_q.shift_reg_en;
  assign finalize_shift_reg           = ctrl_q.finalize_shift_reg;
  assign done                         = ctrl_q.done;
  assign busy                         = ctrl_q.busy;

endmodule

// File: tb/tb_conv_sequencer.sv
// Scoreboard bench: an expected per-cycle timeline is derived from the run
// schedule and compared against the DUT control vector by a monitor.
module tb_conv_sequencer;

  localparam int TB_ROWS = 2;
  localparam int K_INIT = 0, K_LDF = 1, K_LDB = 2, K_WIN = 3, K_MAC = 4,
                 K_ACC = 5, K_WR = 6, K_SHIFT = 7, K_REFILL = 8, K_DONE = 9;

  typedef struct packed {
    logic       load_x;
    logic       sel_x;
    logic       load_y;
    logic       sel_y;
    logic       load_z;
    logic       sel_z;
    logic [1:0] mem_addr_sel;
    logic       mem_write_en;
    logic       write_buff_en;
    logic       write_buff_counter_en;
    logic       shift_buff;
    logic       read_buff_counter_en;
    logic       write_filter_buff_en;
    logic       write_filter_buff_counter_en;
    logic       read_filter_buff_counter_en;
    logic       write_window_buff_en;
    logic       clear_mac;
    logic       partial_res_en;
    logic       shift_reg_en;
    logic       finalize_shift_reg;
    logic       done;
    logic       busy;
  } vec_t;

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic cout_f, cout_m, cout_bw, cout_br;
  logic load_x, sel_x, load_y, sel_y, load_z, sel_z;
  logic [1:0] mem_addr_sel;
  logic mem_write_en, write_buff_en, write_buff_counter_en, shift_buff;
  logic read_buff_counter_en, write_filter_buff_en, write_filter_buff_counter_en;
  logic read_filter_buff_counter_en, write_window_buff_en, clear_mac;
  logic partial_res_en, shift_reg_en, finalize_shift_reg, done, busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int nwr = 0;
  int ndone = 0;
  ev_t ev_q[$];
  vec_t cur;

  conv_sequencer #(.OUT_ROWS(TB_ROWS)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cout_filter_write_index(cout_f), .cout_mac_index(cout_m),
    .cout_buff_write_index(cout_bw), .cout_buff_read_index(cout_br),
    .load_x(load_x), .sel_x(sel_x), .load_y(load_y), .sel_y(sel_y),
    .load_z(load_z), .sel_z(sel_z), .mem_addr_sel(mem_addr_sel),
    .mem_write_en(mem_write_en), .write_buff_en(write_buff_en),
    .write_buff_counter_en(write_buff_counter_en), .shift_buff(shift_buff),
    .read_buff_counter_en(read_buff_counter_en),
    .write_filter_buff_en(write_filter_buff_en),
    .write_filter_buff_counter_en(write_filter_buff_counter_en),
    .read_filter_buff_counter_en(read_filter_buff_counter_en),
    .write_window_buff_en(write_window_buff_en), .clear_mac(clear_mac),
    .partial_res_en(partial_res_en), .shift_reg_en(shift_reg_en),
    .finalize_shift_reg(finalize_shift_reg), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath counter model: 4 filter slots, 4 band rows, 16 taps, 13 columns.
  logic [1:0] fcnt, bwcnt;
  logic [3:0] mcnt, rcnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt <= '0; bwcnt <= '0; mcnt <= '0; rcnt <= '0;
    end else begin
      if (write_filter_buff_counter_en) fcnt <= fcnt + 2'd1;
      if (write_buff_counter_en)        bwcnt <= bwcnt + 2'd1;
      if (read_filter_buff_counter_en)  mcnt <= mcnt + 4'd1;
      if (read_buff_counter_en)         rcnt <= (rcnt == 4'd12) ? 4'd0 : rcnt + 4'd1;
    end
  end
  assign cout_f  = (fcnt == 2'd3);
  assign cout_bw = (bwcnt == 2'd3);
  assign cout_m  = (mcnt == 4'd15);
  assign cout_br = (rcnt == 4'd12);

  always_comb begin
    cur = '0;
    cur.load_x = load_x; cur.sel_x = sel_x; cur.load_y = load_y; cur.sel_y = sel_y;
    cur.load_z = load_z; cur.sel_z = sel_z; cur.mem_addr_sel = mem_addr_sel;
    cur.mem_write_en = mem_write_en; cur.write_buff_en = write_buff_en;
    cur.write_buff_counter_en = write_buff_counter_en; cur.shift_buff = shift_buff;
    cur.read_buff_counter_en = read_buff_counter_en;
    cur.write_filter_buff_en = write_filter_buff_en;
    cur.write_filter_buff_counter_en = write_filter_buff_counter_en;
    cur.read_filter_buff_counter_en = read_filter_buff_counter_en;
    cur.write_window_buff_en = write_window_buff_en; cur.clear_mac = clear_mac;
    cur.partial_res_en = partial_res_en; cur.shift_reg_en = shift_reg_en;
    cur.finalize_shift_reg = finalize_shift_reg; cur.done = done; cur.busy = busy;
  end

  function automatic vec_t exp_vec(int kind);
    vec_t v = '0;
    v.busy = 1'b1;
    case (kind)
      K_INIT:   begin v.load_x = 1; v.load_y = 1; v.load_z = 1; end
      K_LDF:    begin v.mem_addr_sel = 2'd1; v.write_filter_buff_en = 1;
                      v.write_filter_buff_counter_en = 1; v.load_y = 1; v.sel_y = 1; end
      K_LDB:    begin v.write_buff_en = 1; v.write_buff_counter_en = 1;
                      v.load_x = 1; v.sel_x = 1; end
      K_WIN:    begin v.write_window_buff_en = 1; v.clear_mac = 1; end
      K_MAC:    begin v.read_filter_buff_counter_en = 1; v.partial_res_en = 1; end
      K_ACC:    begin v.shift_reg_en = 1; v.read_buff_counter_en = 1; end
      K_WR:     begin v.finalize_shift_reg = 1; v.mem_addr_sel = 2'd2;
                      v.mem_write_en = 1; v.load_z = 1; v.sel_z = 1; end
      K_SHIFT:  v.shift_buff = 1;
      K_REFILL: begin v.write_buff_en = 1; v.load_x = 1; v.sel_x = 1; end
      K_DONE:   v.done = 1;
      default:  v = '0;
    endcase
    return v;
  endfunction

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input int k);
    ev_t e;
    e.cyc = c; e.kind = k;
    ev_q.push_back(e);
  endtask

  // Run schedule: 1 INIT, 4 filter loads, 4 band loads, then per row 13 windows
  // of 18 cycles with a write after every 4th window and at row end.
  task automatic push_run(input int s, output int done_cyc);
    int t;
    push(s + 1, K_INIT);
    for (int i = 2; i <= 5; i++) push(s + i, K_LDF);
    for (int i = 6; i <= 9; i++) push(s + i, K_LDB);
    t = s + 10;
    done_cyc = -1;
    for (int r = 0; r < TB_ROWS; r++) begin
      for (int w = 0; w < 13; w++) begin
        push(t, K_WIN);
        for (int m = 1; m <= 16; m++) push(t + m, K_MAC);
        push(t + 17, K_ACC);
        t += 18;
        if (w % 4 == 3 || w == 12) begin push(t, K_WR); t++; end
      end
      if (r == TB_ROWS - 1) begin
        push(t, K_DONE);
        done_cyc = t;
      end else begin
        push(t, K_SHIFT); push(t + 1, K_REFILL);
        t += 2;
      end
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (cur.busy) begin
      if (ev_q.size() == 0) begin
        chk(1'b0, "unexpected_busy", longint'(cur), 0);
      end else begin
        e = ev_q.pop_front();
        chk(e.cyc == cyc, "event_cycle", cyc, e.cyc);
        chk(cur == exp_vec(e.kind), "ctrl_vector", longint'(cur), longint'(exp_vec(e.kind)));
        if (cur.mem_write_en) nwr++;
        if (cur.done) ndone++;
      end
    end else if (ev_q.size() != 0 && ev_q[0].cyc <= cyc) begin
      e = ev_q.pop_front();
      chk(1'b0, "missing_event", longint'(cur), longint'(exp_vec(e.kind)));
    end else begin
      chk(cur == '0, "idle_zero", longint'(cur), 0);
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic full_run(input string tag);
    int s, d;
    nwr = 0; ndone = 0;
    start = 1'b1;
    s = cyc;
    push_run(s, d);
    next_cycle();
    start = 1'b0;
    while (cyc < d + 3) begin
      start = (cyc < d - 1) && ($urandom_range(0, 7) == 0);
      next_cycle();
    end
    start = 1'b0;
    chk(nwr == 8, {tag, "_write_count"}, nwr, 8);
    chk(ndone == 1, {tag, "_done_count"}, ndone, 1);
  endtask

  initial begin
    int s, d, gap;
    for (int i = 0; i < 6; i++) begin
      start = ~start;
      next_cycle();
    end
    start = 1'b0;
    rst = 1'b1;
    repeat (20) next_cycle();

    full_run("run1");

    // abort mid-MAC, then a fresh run must follow the same schedule
    start = 1'b1;
    s = cyc;
    push_run(s, d);
    next_cycle();
    start = 1'b0;
    gap = $urandom_range(12, 40);
    while (cyc < s + gap) next_cycle();
    rst = 1'b0;
    ev_q.delete();
    #1;
    chk(cur == '0, "abort_zero", longint'(cur), 0);
    repeat (3) next_cycle();
    rst = 1'b1;
    repeat ($urandom_range(1, 10)) next_cycle();
    full_run("run2");

    repeat ($urandom_range(2, 15)) next_cycle();
    full_run("run3");

    repeat (5) next_cycle();
    chk(ev_q.size() == 0, "queue_drained", ev_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
- Moore FSM that sequences the 4x4-filter convolution datapath from a single start pulse to a done pulse.
- Loads the filter and the first 4-row image band, then runs one 16-cycle MAC pass per window.
- Packs results four at a time into the output shift register and writes each packed word at the z pointer.
- Slides the band down one row until OUT_ROWS output rows are produced. Sits beside the datapath, driving all of its control inputs and consuming its four counter carry-outs.

Parameters:
- OUT_ROWS, 13: output rows per run (band slides); legal range 1..15.
- GROUP, 4: results packed per memory write. Fixed; not overridable.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin run; sampled in IDLE only
- cout_filter_write_index  in  1  filter write counter at last slot
- cout_mac_index  in  1  MAC read counter at last (16th) tap
- cout_buff_write_index  in  1  buffer write counter at last row
- cout_buff_read_index  in  1  window column counter at last (13th) position
- load_x, sel_x, load_y, sel_y, load_z, sel_z  out  1 each  pointer load enables and selects (sel=0 initial value, sel=1 increment)
- mem_addr_sel  out  2  0=x, 1=y, 2=z
- mem_write_en  out  1  memory write strobe
- write_buff_en, write_buff_counter_en, shift_buff  out  1 each  image buffer controls
- read_buff_counter_en  out  1  advance window column
- write_filter_buff_en, write_filter_buff_counter_en  out  1 each  filter buffer controls
- read_filter_buff_counter_en  out  1  advance tap index
- write_window_buff_en, clear_mac, partial_res_en  out  1 each  window/MAC controls
- shift_reg_en, finalize_shift_reg  out  1 each  result packer controls
- done  out  1  one-cycle end-of-run pulse (also drives memory dump)
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, row_cnt=0, grp_cnt=0. Every output is 0, including mem_addr_sel=0. Reset mid-run aborts immediately; no memory write completes after reset asserts.
- All outputs decode from the state register only (Moore). Outputs not listed for a state are 0.
- IDLE: start=1 -> INIT. While not in IDLE, start is ignored.
- INIT (1 cycle): load_x=load_y=load_z=1, sel_*=0 -> LD_FILT.
- LD_FILT: mem_addr_sel=1, write_filter_buff_en=1, write_filter_buff_counter_en=1, load_y=1, sel_y=1. Exit on cout_filter_write_index=1 -> LD_BUFF. Nominal length 4 cycles.
- LD_BUFF: mem_addr_sel=0, write_buff_en=1, write_buff_counter_en=1, load_x=1, sel_x=1. Exit on cout_buff_write_index=1 -> LD_WIN. Nominal length 4 cycles.
- LD_WIN (1 cycle): write_window_buff_en=1, clear_mac=1 -> MAC.
- MAC: read_filter_buff_counter_en=1, partial_res_en=1. Exit on cout_mac_index=1 -> ACC. Nominal length 16 cycles.
- ACC (1 cycle): shift_reg_en=1, read_buff_counter_en=1, grp_cnt increments mod 4. Transitions:
  - if cout_buff_read_index=1 (row end) -> WR with row_end flag set;
  - else if grp_cnt==3 -> WR;
  - else -> LD_WIN.
- WR (1 cycle): finalize_shift_reg=1, mem_addr_sel=2, mem_write_en=1, load_z=1, sel_z=1; grp_cnt:=0. Transitions:
  - if row_end clear -> LD_WIN;
  - else if row_cnt==OUT_ROWS-1 -> DONE;
  - else -> SHIFT.
  - A partial group (fewer than 4 results at row end) is still written; unfilled lanes are whatever the shift register holds.
- SHIFT (1 cycle): shift_buff=1 -> REFILL.
- REFILL (1 cycle): mem_addr_sel=0, write_buff_en=1, load_x=1, sel_x=1. Writes one new row into the slot freed by the shift. row_cnt++, row_end cleared -> LD_WIN.
- DONE (1 cycle): done=1 -> IDLE. row_cnt and grp_cnt reset to 0.
- Simultaneous events: in ACC, row end and a full group both lead to a single WR.
- Counter wrap: datapath counters wrap on their own; the sequencer never clears them.
- Per window: 18 cycles (LD_WIN + 16 MAC + ACC).

Test Plan:
- Reset/idle: hold rst=0, toggle start -> all outputs 0, busy=0. Release rst, no start for 20 cycles -> outputs stay 0.
- First window timing (datapath model with correct counters): start at cycle 0 ->
  - INIT at 1; LD_FILT 2-5 with mem_addr_sel=1; LD_BUFF 6-9 with mem_addr_sel=0;
  - clear_mac at 10; partial_res_en 11-26; shift_reg_en at 27.
- Group write: continue -> shift_reg_en at 27, 45, 63, 81; mem_write_en with mem_addr_sel=2 and load_z at 82. Exactly one write per 4 results.
- Row end: 13th ACC with cout_buff_read_index=1 -> partial WR (1 result), then shift_buff for 1 cycle, then REFILL with write_buff_en and load_x, then LD_WIN.
- Full run with OUT_ROWS=2 -> exactly 8 mem_write_en pulses (4 per row), then one done pulse. busy falls the cycle after done; start asserted during the run has no effect.
- Async abort: drop rst mid-MAC (e.g. cycle 15) -> outputs 0 immediately. After release and a new start, the sequence repeats from INIT with identical timing.
